// File: rtl/tl_phase_scheduler.sv
// Two-road demand-actuated phase scheduler: green/yellow/all-red sequencing with min/max green and night flashing yellow.
// Lamps decode combinationally from registered state; phase_start and counters are registered.
module tl_phase_scheduler #(
    parameter int CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_1s,
    input  logic                 hold,
    input  logic                 night_mode,
    input  logic                 req1,
    input  logic                 req2,
    input  logic [CNT_WIDTH-1:0] cfg_min_green,
    input  logic [CNT_WIDTH-1:0] cfg_max_green,
    input  logic [CNT_WIDTH-1:0] cfg_yellow,
    input  logic [CNT_WIDTH-1:0] cfg_allred,
    output logic                 R1,
    output logic                 Y1,
    output logic                 G1,
    output logic                 R2,
    output logic                 Y2,
    output logic                 G2,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 phase_start,
    output logic                 req1_pending,
    output logic                 req2_pending
);

    typedef enum logic [2:0] {
        S_NIGHT = 3'd0,
        S_G1    = 3'd1,
        S_Y1    = 3'd2,
        S_AR1   = 3'd3,
        S_G2    = 3'd4,
        S_Y2    = 3'd5,
        S_AR2   = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
    logic                 p1_q, p1_d;
    logic                 p2_q, p2_d;
    logic                 blink_q, blink_d;
    logic                 ps_q, ps_d;
    logic                 entry;
    logic                 second;
    logic                 cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign second   = tick_1s && !hold;

    always_comb begin
        state_d = state_q;
        if (night_mode) begin
            state_d = S_NIGHT;
        end else begin
            case (state_q)
                S_NIGHT: state_d = S_AR2;
                S_G1:    if (p2_q && (elapsed_q >= cfg_min_green || cnt_zero)) state_d = S_Y1;
                S_Y1:    if (cnt_zero) state_d = S_AR1;
                S_AR1:   if (cnt_zero) state_d = S_G2;
                S_G2:    if (p1_q && (elapsed_q >= cfg_min_green || cnt_zero)) state_d = S_Y2;
                S_Y2:    if (cnt_zero) state_d = S_AR2;
                S_AR2:   if (cnt_zero) state_d = S_G1;
                default: state_d = S_AR2;
            endcase
        end
    end

    assign entry = (state_d != state_q);

    // Durations are captured only on phase entry; mid-phase cfg edits wait for the next phase.
    always_comb begin
        cnt_d     = cnt_q;
        elapsed_d = elapsed_q;
        if (entry) begin
            elapsed_d = '0;
            case (state_d)
                S_G1, S_G2:   cnt_d = cfg_max_green;
                S_Y1, S_Y2:   cnt_d = cfg_yellow;
                S_AR1, S_AR2: cnt_d = cfg_allred;
                default:      cnt_d = '0;
            endcase
        end else if (second) begin
            if (!cnt_zero)        cnt_d     = cnt_q - ONE;
            if (elapsed_q != '1)  elapsed_d = elapsed_q + ONE;
        end
    end

    always_comb begin
        p1_d = p1_q;
        p2_d = p2_q;
        if (req1 && state_q != S_G1) p1_d = 1'b1;
        if (req2 && state_q != S_G2) p2_d = 1'b1;
        if (entry && state_d == S_G1) p1_d = 1'b0;
        if (entry && state_d == S_G2) p2_d = 1'b0;
        if (state_d == S_NIGHT || state_q == S_NIGHT) begin
            p1_d = 1'b0;
            p2_d = 1'b0;
        end
    end

    // Blink runs off the raw tick so the night flash keeps going in settings mode.
    always_comb begin
        blink_d = blink_q;
        if (entry && state_d == S_NIGHT)          blink_d = 1'b0;
        else if (state_q == S_NIGHT && tick_1s)   blink_d = !blink_q;
        ps_d = entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_AR2;
            cnt_q     <= cfg_allred;
            elapsed_q <= '0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            blink_q   <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            blink_q   <= blink_d;
            ps_q      <= ps_d;
        end
    end

    always_comb begin
        R1 = 1'b0;
        Y1 = 1'b0;
        G1 = 1'b0;
        R2 = 1'b0;
        Y2 = 1'b0;
        G2 = 1'b0;
        case (state_q)
            S_G1:    begin G1 = 1'b1; R2 = 1'b1; end
            S_Y1:    begin Y1 = 1'b1; R2 = 1'b1; end
            S_G2:    begin R1 = 1'b1; G2 = 1'b1; end
            S_Y2:    begin R1 = 1'b1; Y2 = 1'b1; end
            S_NIGHT: begin Y1 = blink_q; Y2 = blink_q; end
            default: begin R1 = 1'b1; R2 = 1'b1; end
        endcase
    end

    assign phase        = state_q;
    assign cnt          = cnt_q;
    assign phase_start  = ps_q;
    assign req1_pending = p1_q;
    assign req2_pending = p2_q;

endmodule
